// File: rtl/sys_defs.sv
// Shared definitions for the tagged split-transaction data-memory protocol:
// command encoding, tag and block types, default depth/latency, and the
// response pipeline stage record.
package sys_defs;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;

  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_LATENCY  = 4;

  typedef struct packed {
    logic     valid;
    MEM_TAG   tag;
    MEM_BLOCK data;
  } DMEM_RESP_STAGE;

endpackage

// File: rtl/mem_tag_freelist.sv
// Tag free list: one bit per usable tag (bit i <-> tag i+1), lowest-free
// priority grant. Tag 0 is never granted; grant_tag==0 means none free.
module mem_tag_freelist
  import sys_defs::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   alloc,
  input  logic   release_valid,
  input  MEM_TAG release_tag,
  output MEM_TAG grant_tag,
  output logic   any_free
);

  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] free_mask_next;

  // Lowest free tag wins; scanning downward leaves the lowest index last.
  always_comb begin
    grant_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) grant_tag = MEM_TAG'(i + 1);
    end
  end

  assign any_free = |free_mask;

  // Reserve the granted tag and return the releasing tag. A releasing tag is
  // never free in the same cycle, so the two never touch the same bit.
  always_comb begin
    free_mask_next = free_mask;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc && (grant_tag == MEM_TAG'(i + 1)))
        free_mask_next[i] = 1'b0;
      if (release_valid && (release_tag == MEM_TAG'(i + 1)))
        free_mask_next[i] = 1'b1;
    end
  end

  // Free mask register; all tags free out of reset.
  always_ff @(posedge clock) begin
    if (reset) free_mask <= '1;
    else       free_mask <= free_mask_next;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: backing store, tag allocation and a fixed-latency
// load return pipeline. Optional build macro DMEM_STALL_INJECT_EN adds an
// LFSR that randomly rejects commands to exercise initiator retry paths.
module dmem_responder
  import sys_defs::*;
#(
  parameter int MEM_BLOCKS = 1024,
  parameter int LATENCY    = MEM_LATENCY,
  parameter int NUM_TAGS   = NUM_MEM_TAGS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_transaction_tag,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_data_tag,
  output logic [3:0]  outstanding
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);

  MEM_BLOCK       mem [MEM_BLOCKS];
  DMEM_RESP_STAGE pipe [LATENCY];

  logic [IDX_W-1:0] idx;
  logic             is_load;
  logic             is_store;
  logic             stall;
  logic             accept;
  logic             load_accept;
  logic             store_accept;
  logic             resp_valid;
  MEM_TAG           grant_tag;
  logic             any_free;

  // Offset bits and bits above the store size are don't-care (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[31:3+IDX_W]};

  assign idx      = proc2mem_addr[3 +: IDX_W];
  assign is_load  = (proc2mem_command == MEM_LOAD);
  assign is_store = (proc2mem_command == MEM_STORE);

`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running stall source.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign accept       = (is_load || is_store) && any_free && !stall && !reset;
  assign load_accept  = is_load && accept;
  assign store_accept = is_store && accept;
  assign resp_valid   = pipe[LATENCY-1].valid;

  assign mem2proc_transaction_tag = accept ? grant_tag : '0;

  mem_tag_freelist #(
    .NUM_TAGS (NUM_TAGS)
  ) u_freelist (
    .clock         (clock),
    .reset         (reset),
    .alloc         (load_accept),
    .release_valid (resp_valid),
    .release_tag   (pipe[LATENCY-1].tag),
    .grant_tag     (grant_tag),
    .any_free      (any_free)
  );

  // Backing store; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (store_accept) mem[idx] <= proc2mem_data;
  end

  // Response pipeline: load data is captured at acceptance, so later stores
  // to the same block cannot alter a load already in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (load_accept) pipe[0] <= '{valid: 1'b1, tag: grant_tag, data: mem[idx]};
      else             pipe[0] <= '0;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem2proc_data     = pipe[LATENCY-1].data;
  assign mem2proc_data_tag = pipe[LATENCY-1].tag;

  // Loads in flight: up on accept, down on response, net zero if both.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({load_accept, resp_valid})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
